// File: rtl/matmul_rr_scheduler.sv
// Round-robin scheduler sharing one 2x2 matrix multiplier among NUM_REQ requesters.
// Each operation is aborted if it runs past TIMEOUT cycles. Successful completions are counted.
module matmul_rr_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ*64-1:0] req_a,
    input  logic [NUM_REQ*64-1:0] req_b,
    output logic [NUM_REQ-1:0]    grant,
    output logic [NUM_REQ-1:0]    rsp_valid,
    output logic [127:0]          rsp_c,
    output logic                  rsp_err,
    output logic                  mm_start,
    output logic [63:0]           mm_a,
    output logic [63:0]           mm_b,
    input  logic                  mm_busy,
    input  logic                  mm_done,
    input  logic [127:0]          mm_c,
    output logic [15:0]           op_count
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int TW = $clog2(TIMEOUT + 1);

    // IDLE arbitrate | START hold mm_start until busy | WAIT await done/timeout | RESP one-cycle response
    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_RESP} state_t;

    state_t               state, state_nxt;
    logic [NUM_REQ-1:0]   grant_nxt, rsp_valid_nxt;
    logic [127:0]         rsp_c_nxt;
    logic                 rsp_err_nxt, mm_start_nxt;
    logic [63:0]          mm_a_nxt, mm_b_nxt;
    logic [15:0]          op_count_nxt;
    logic [TW-1:0]        tmo_cnt, tmo_nxt;
    logic [IW-1:0]        last_grant, last_nxt;
    logic                 win_found;
    logic [IW-1:0]        win_idx;
    int                   cand;

    // Search upward from the requester after the last winner, wrapping around.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand = (int'(last_grant) + off) % NUM_REQ;
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = IW'(cand);
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        grant_nxt     = grant;
        rsp_valid_nxt = '0;
        rsp_c_nxt     = rsp_c;
        rsp_err_nxt   = rsp_err;
        mm_start_nxt  = mm_start;
        mm_a_nxt      = mm_a;
        mm_b_nxt      = mm_b;
        op_count_nxt  = op_count;
        tmo_nxt       = tmo_cnt;
        last_nxt      = last_grant;
        case (state)
            S_IDLE: begin
                if (win_found) begin
                    grant_nxt          = '0;
                    grant_nxt[win_idx] = 1'b1;
                    last_nxt           = win_idx;
                    mm_a_nxt           = req_a[64*win_idx +: 64];
                    mm_b_nxt           = req_b[64*win_idx +: 64];
                    mm_start_nxt       = 1'b1;
                    tmo_nxt            = '0;
                    state_nxt          = S_START;
                end
            end
            S_START, S_WAIT: begin
                // mm_done is stale in START, so completion is only honoured in WAIT
                if (state == S_WAIT && mm_done && !mm_busy) begin
                    rsp_c_nxt     = mm_c;
                    rsp_err_nxt   = 1'b0;
                    rsp_valid_nxt = grant;
                    op_count_nxt  = op_count + 16'd1;
                    state_nxt     = S_RESP;
                end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
                    mm_start_nxt  = 1'b0;
                    rsp_c_nxt     = '0;
                    rsp_err_nxt   = 1'b1;
                    rsp_valid_nxt = grant;
                    tmo_nxt       = TW'(TIMEOUT);
                    state_nxt     = S_RESP;
                end else begin
                    tmo_nxt = tmo_cnt + TW'(1);
                    if (state == S_START && mm_busy) begin
                        mm_start_nxt = 1'b0;
                        state_nxt    = S_WAIT;
                    end
                end
            end
            S_RESP: begin
                grant_nxt = '0;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            grant      <= '0;
            rsp_valid  <= '0;
            rsp_c      <= '0;
            rsp_err    <= 1'b0;
            mm_start   <= 1'b0;
            mm_a       <= '0;
            mm_b       <= '0;
            op_count   <= '0;
            tmo_cnt    <= '0;
            last_grant <= IW'(NUM_REQ - 1);
        end else begin
            state      <= state_nxt;
            grant      <= grant_nxt;
            rsp_valid  <= rsp_valid_nxt;
            rsp_c      <= rsp_c_nxt;
            rsp_err    <= rsp_err_nxt;
            mm_start   <= mm_start_nxt;
            mm_a       <= mm_a_nxt;
            mm_b       <= mm_b_nxt;
            op_count   <= op_count_nxt;
            tmo_cnt    <= tmo_nxt;
            last_grant <= last_nxt;
        end
    end
endmodule

// File: tb/tb_matmul_rr_scheduler.sv
// Directed bench for matmul_rr_scheduler with a behavioural 2x2 multiplier stub
// (busy one cycle after start, done three cycles after busy, done held until next start).
module tb_matmul_rr_scheduler;
    localparam int NUM_REQ = 4;
    localparam int TIMEOUT = 16;

    logic                  clk, rst;
    logic [NUM_REQ-1:0]    req;
    logic [NUM_REQ*64-1:0] req_a, req_b;
    logic [NUM_REQ-1:0]    grant, rsp_valid;
    logic [127:0]          rsp_c;
    logic                  rsp_err, mm_start;
    logic [63:0]           mm_a, mm_b;
    logic                  mm_busy, mm_done;
    logic [127:0]          mm_c;
    logic [15:0]           op_count;

    matmul_rr_scheduler #(.NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .req(req), .req_a(req_a), .req_b(req_b),
        .grant(grant), .rsp_valid(rsp_valid), .rsp_c(rsp_c), .rsp_err(rsp_err),
        .mm_start(mm_start), .mm_a(mm_a), .mm_b(mm_b),
        .mm_busy(mm_busy), .mm_done(mm_done), .mm_c(mm_c), .op_count(op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] pk16(input int x0, input int x1, input int x2, input int x3);
        return {16'(x0), 16'(x1), 16'(x2), 16'(x3)};
    endfunction

    function automatic logic [127:0] pk32(input int x0, input int x1, input int x2, input int x3);
        return {32'(x0), 32'(x1), 32'(x2), 32'(x3)};
    endfunction

    function automatic logic [127:0] mat_mul(input logic [63:0] a, input logic [63:0] b);
        logic [31:0] a00, a01, a10, a11, b00, b01, b10, b11;
        a00 = 32'(a[63:48]); a01 = 32'(a[47:32]); a10 = 32'(a[31:16]); a11 = 32'(a[15:0]);
        b00 = 32'(b[63:48]); b01 = 32'(b[47:32]); b10 = 32'(b[31:16]); b11 = 32'(b[15:0]);
        return {a00*b00 + a01*b10, a00*b01 + a01*b11, a10*b00 + a11*b10, a10*b01 + a11*b11};
    endfunction

    // Multiplier stub; the product uses the live operand ports so unstable operands show up.
    logic tie_busy;
    int   m_cnt;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mm_busy <= 1'b0;
            mm_done <= 1'b0;
            mm_c    <= '0;
            m_cnt   <= 0;
        end else if (mm_busy) begin
            if (m_cnt == 2) begin
                mm_busy <= 1'b0;
                mm_done <= 1'b1;
                mm_c    <= mat_mul(mm_a, mm_b);
            end else begin
                m_cnt <= m_cnt + 1;
            end
        end else if (mm_start && !tie_busy) begin
            mm_busy <= 1'b1;
            mm_done <= 1'b0;
            m_cnt   <= 0;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_grant(output int gcyc);
        int n = 0;
        while (grant == '0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        gcyc = cyc;
    endtask

    task automatic wait_rsp(input int gcyc, output int lat);
        int n = 0;
        while (rsp_valid == '0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        lat = (rsp_valid != '0) ? cyc - gcyc : -1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (grant != '0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("idle_reached", 128'(grant), 128'(0));
    endtask

    typedef struct {
        int                 idx;
        logic [63:0]        a;
        logic [63:0]        b;
        logic [NUM_REQ-1:0] grant;
        logic [127:0]       c;
    } vec_t;

    vec_t vecs[5];
    int   g, lat, prev, exp_ops, rel_cyc;

    initial begin
        vecs[0] = '{0, pk16(1,0,0,1),          pk16(1,2,3,4),      4'b0001, pk32(1,2,3,4)};
        vecs[1] = '{0, pk16(2,0,0,2),          pk16(3,3,3,3),      4'b0001, pk32(6,6,6,6)};
        vecs[2] = '{1, pk16(1,2,3,4),          pk16(5,6,7,8),      4'b0010, pk32(19,22,43,50)};
        vecs[3] = '{3, pk16(65535,0,0,65535),  pk16(65535,1,0,0),  4'b1000,
                    {32'hFFFE0001, 32'h0000FFFF, 32'h0, 32'h0}};
        vecs[4] = '{2, pk16(2,3,4,5),          pk16(1,0,0,1),      4'b0100, pk32(2,3,4,5)};

        rst = 1'b1; req = '0; req_a = '0; req_b = '0; tie_busy = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_grant",    128'(grant),     128'(0));
        chk("rst_rsp_valid",128'(rsp_valid), 128'(0));
        chk("rst_rsp",      {127'(rsp_c), rsp_err}, 128'(0));
        chk("rst_mm",       {63'(mm_start), mm_a}, 128'(0));
        chk("rst_mm_b",     128'(mm_b),      128'(0));
        chk("rst_op_count", 128'(op_count),  128'(0));
        rst = 1'b0;
        exp_ops = 0;

        for (int i = 0; i < 5; i++) begin
            req[vecs[i].idx] = 1'b1;
            req_a[64*vecs[i].idx +: 64] = vecs[i].a;
            req_b[64*vecs[i].idx +: 64] = vecs[i].b;
            wait_grant(g);
            chk("vec_grant", 128'(grant), 128'(vecs[i].grant));
            wait_rsp(g, lat);
            exp_ops++;
            chk("vec_latency",   128'(lat),       128'(5));
            chk("vec_rsp_valid", 128'(rsp_valid), 128'(vecs[i].grant));
            chk("vec_rsp_c",     rsp_c,           vecs[i].c);
            chk("vec_rsp_err",   128'(rsp_err),   128'(0));
            chk("vec_op_count",  128'(op_count),  128'(exp_ops));
            req[vecs[i].idx] = 1'b0;
            wait_idle();
        end

        // Round-robin from reset with all requesters held
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_ops = 0;
        for (int s = 0; s < NUM_REQ; s++) begin
            req_a[64*s +: 64] = pk16(1,0,0,1);
            req_b[64*s +: 64] = pk16(s+1, s+1, s+1, s+1);
        end
        req = '1;
        prev = 0;
        for (int k = 0; k < 5; k++) begin
            wait_grant(g);
            chk("rr_grant", 128'(grant), 128'(1) << (k % 4));
            if (k > 0) chk("rr_period", 128'(g - prev), 128'(7));
            prev = g;
            if (k == 4) req = 4'b0001;
            wait_rsp(g, lat);
            exp_ops++;
            chk("rr_rsp_c", rsp_c, pk32(k%4+1, k%4+1, k%4+1, k%4+1));
            if (k == 4) req = '0;
            wait_idle();
        end
        chk("rr_op_count", 128'(op_count), 128'(exp_ops));

        // Operand change after the grant edge
        req_a[64 +: 64] = pk16(1,0,0,1);
        req_b[64 +: 64] = pk16(7,8,9,10);
        req = 4'b0010;
        wait_grant(g);
        chk("opchg_grant", 128'(grant), 128'(4'b0010));
        @(negedge clk);
        req_a[64 +: 64] = pk16(5,5,5,5);
        req_b[64 +: 64] = pk16(1,1,1,1);
        wait_rsp(g, lat);
        exp_ops++;
        chk("opchg_latency", 128'(lat),   128'(5));
        chk("opchg_rsp_c",   rsp_c,       pk32(7,8,9,10));
        chk("opchg_mm_a",    128'(mm_a),  128'(pk16(1,0,0,1)));
        chk("opchg_op_count",128'(op_count), 128'(exp_ops));
        req = '0;
        wait_idle();

        // Timeout: multiplier never goes busy
        tie_busy = 1'b1;
        req_a[128 +: 64] = pk16(1,0,0,1);
        req_b[128 +: 64] = pk16(9,9,9,9);
        req = 4'b0100;
        wait_grant(g);
        chk("tmo_grant", 128'(grant), 128'(4'b0100));
        wait_rsp(g, lat);
        chk("tmo_latency",   128'(lat),       128'(TIMEOUT));
        chk("tmo_rsp_valid", 128'(rsp_valid), 128'(4'b0100));
        chk("tmo_rsp_err",   128'(rsp_err),   128'(1));
        chk("tmo_rsp_c",     rsp_c,           128'(0));
        chk("tmo_mm_start",  128'(mm_start),  128'(0));
        chk("tmo_op_count",  128'(op_count),  128'(exp_ops));
        req = '0;
        wait_idle();
        tie_busy = 1'b0;

        req_a[192 +: 64] = pk16(1,1,1,1);
        req_b[192 +: 64] = pk16(1,2,3,4);
        req = 4'b1000;
        wait_grant(g);
        chk("post_tmo_grant", 128'(grant), 128'(4'b1000));
        wait_rsp(g, lat);
        exp_ops++;
        chk("post_tmo_latency", 128'(lat),     128'(5));
        chk("post_tmo_rsp_err", 128'(rsp_err), 128'(0));
        chk("post_tmo_rsp_c",   rsp_c,         pk32(4,6,4,6));
        chk("post_tmo_op_count",128'(op_count),128'(exp_ops));
        req = '0;
        wait_idle();

        // Reset while in WAIT
        req_a[0 +: 64] = pk16(1,0,0,1);
        req_b[0 +: 64] = pk16(1,2,3,4);
        req = 4'b0001;
        wait_grant(g);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rstw_grant",     128'(grant),     128'(0));
        chk("rstw_rsp_valid", 128'(rsp_valid), 128'(0));
        chk("rstw_mm",        {63'(mm_start), mm_a}, 128'(0));
        chk("rstw_op_count",  128'(op_count),  128'(0));
        req = 4'b0100;
        repeat (2) @(negedge clk);
        chk("rstw_no_rsp", 128'(rsp_valid), 128'(0));
        rst = 1'b0;
        rel_cyc = cyc;
        wait_grant(g);
        chk("rstw_regrant",       128'(grant),       128'(4'b0100));
        chk("rstw_regrant_cycle", 128'(g - rel_cyc), 128'(1));
        req = '0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/matmul_rr_scheduler.md
MATMUL_RR_SCHEDULER -- requirements
Module: matmul_rr_scheduler

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters; legal range 2..8.
REQ-002 Parameter TIMEOUT, default 16: maximum cycles spent in START plus WAIT before the operation is aborted.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 req  in  NUM_REQ  level request per requester; held until that requester's rsp_valid pulse.
REQ-006 req_a  in  NUM_REQ*64  per-requester A operands, slot i = bits [64i+63:64i], packed {a00,a01,a10,a11}, 16 b each, a00 in the MS bits.
REQ-007 req_b  in  NUM_REQ*64  per-requester B operands, same packing as req_a.
REQ-008 grant  out  NUM_REQ  one-hot owner of the multiplier; all zero when idle.
REQ-009 rsp_valid  out  NUM_REQ  one-cycle one-hot completion pulse to the owner.
REQ-010 rsp_c  out  128  result {c00,c01,c10,c11}, 32 b each; valid only while rsp_valid is nonzero.
REQ-011 rsp_err  out  1  qualifies rsp_valid; 1 = aborted by timeout.
REQ-012 mm_start, mm_a[63:0], mm_b[63:0]  out  drive the 2x2 multiplier's start and operand inputs.
REQ-013 mm_busy, mm_done  in  1 each; mm_c  in  128  multiplier status and results.
REQ-014 op_count  out  16  count of successful completions; wraps from 0xFFFF to 0.

Function
REQ-015 The FSM SHALL have states IDLE, START, WAIT and RESP.
REQ-016 IDLE: if any req bit is 1, then at that edge:
- pick the winner round-robin, searching upward from (last_grant+1) mod NUM_REQ;
- latch the winner's operands into mm_a/mm_b;
- set grant to the winner and mm_start=1;
- clear the timeout counter;
- go to START.
REQ-017 mm_a and mm_b SHALL be registered and SHALL stay constant from the grant edge until the FSM returns to IDLE.
REQ-018 START: mm_start SHALL stay 1 until mm_busy=1 is sampled; at that edge the block SHALL drive mm_start=0 and go to WAIT.
REQ-019 The block SHALL ignore mm_done while in START, because done stays high from the previous operation.
REQ-020 WAIT: on sampling mm_done=1 and mm_busy=0, the block SHALL:
- register mm_c into rsp_c;
- pulse rsp_valid for the owner with rsp_err=0;
- increment op_count;
- go to RESP.
REQ-021 RESP: rsp_valid SHALL be high for exactly this one cycle. Grant clears and the FSM goes to IDLE at the next edge.
REQ-022 The owner's req SHALL NOT be sampled for arbitration until the edge after RESP.
REQ-023 last_grant SHALL update only at the grant edge; its reset value is NUM_REQ-1, so requester 0 wins first.
REQ-024 The timeout counter SHALL increment every cycle in START and WAIT. When it reaches TIMEOUT, the block SHALL:
- drive mm_start=0;
- set rsp_c=0 and rsp_err=1;
- pulse rsp_valid for the owner;
- go to RESP, leaving op_count unchanged.
REQ-025 A requester that drops req before it is granted SHALL simply not be served; there is no queueing.
REQ-026 Changes to req_a/req_b after the grant edge SHALL have no effect on the operation in flight.
REQ-027 With the standard multiplier (busy one cycle after start; done three cycles after busy), rsp_valid SHALL assert 5 cycles after the grant edge, and back-to-back service SHALL take 7 cycles per operation.

Reset
REQ-028 rst=1 SHALL immediately force: state=IDLE, grant=0, rsp_valid=0, rsp_c=0, rsp_err=0, mm_start=0, mm_a=0, mm_b=0, op_count=0, timeout counter=0, last_grant=NUM_REQ-1.
REQ-029 Reset mid-operation SHALL abort the operation with no rsp_valid pulse. The multiplier shares rst and also returns to idle.
REQ-030 After rst deasserts, the first grant SHALL occur at the first posedge that sees any req=1.

Verification
REQ-031 Single op: req[0]=1 with A=I and B={1,2,3,4} -> grant=0001; rsp_valid=0001 five cycles later; rsp_c={1,2,3,4}; op_count=1.
REQ-032 Round-robin: req=1111 held and re-raised after each response -> grant order 0,1,2,3,0.
REQ-033 Stale done: a second op on the same requester -> no rsp_valid before the new mm_busy, and rsp_c equals the new product ({2,0,0,2}x{3,3,3,3} -> {6,6,6,6}).
REQ-034 Operand change: req_a altered one cycle after grant -> rsp_c reflects the latched operands.
REQ-035 Timeout: multiplier model with mm_busy tied 0 -> rsp_valid at cycle TIMEOUT with rsp_err=1 and rsp_c=0; op_count unchanged; next requester then served normally.
REQ-036 Reset in WAIT -> all outputs 0 at once, no rsp_valid pulse; after release, req[2] only -> grant=0100.
